board_reset_input_cond: RTL and testbench

//  Board-level reset sequencer and button conditioner for the FPGA top levels. Sits between
//  the PLL/board pins and the tt_um_* core; drives the core's rst_n and its debounced ui_in

---
 rtl/board_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 68 ++++++
 rtl/board_reset_input_cond.sv | 134 +++++++++++++
 tb/tb_board_reset_input_cond.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared types and default cycle constants for the board reset / button conditioning logic.
package board_pkg;

  typedef enum logic [1:0] {
    POR_WAIT = 2'd0,
    RUN      = 2'd1,
    HOLD_RST = 2'd2
  } brst_state_t;

  // 25.125 MHz pixel clock: ~4.8 ms debounce, ~1 s hold and heartbeat half-period
  localparam int unsigned CLK25_DEBOUNCE_CYC = 120000;
  localparam int unsigned CLK25_POR_CYC      = 512;
  localparam int unsigned CLK25_HOLD_CYC     = 25200000;
  localparam int unsigned CLK25_HB_CYC       = 25200000;

  localparam int unsigned CLK50_DEBOUNCE_CYC = 240000;
  localparam int unsigned CLK50_POR_CYC      = 1024;
  localparam int unsigned CLK50_HOLD_CYC     = 50400000;
  localparam int unsigned CLK50_HB_CYC       = 50400000;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, polarity normalisation, stability counter, edge pulses.
module btn_debounce
  import board_pkg::*;
#(
  parameter bit          ACT_LOW      = 1'b0,
  parameter int unsigned DEBOUNCE_CYC = CLK25_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          w_btn_s;

  assign w_btn_s = r_sync2 ^ ACT_LOW;

  // Synchroniser resets to the idle pin level so release of reset never looks like a press
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= ACT_LOW;
      r_sync2 <= ACT_LOW;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (w_btn_s != r_level) begin
        if (r_cnt == CNT_MAX) begin
          r_cnt     <= '0;
          r_level   <= w_btn_s;
          r_press   <= w_btn_s;
          r_release <= ~w_btn_s;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: rtl/board_reset_input_cond.sv
// Board-level reset sequencer (PLL-lock gated power-on stretch, hold-to-reset) and N-channel button conditioner.
module board_reset_input_cond
  import board_pkg::*;
#(
  parameter int unsigned          N_BTN        = 4,
  parameter logic [N_BTN-1:0]     BTN_ACT_LOW  = 'b0001,
  parameter int unsigned          DEBOUNCE_CYC = CLK25_DEBOUNCE_CYC,
  parameter int unsigned          POR_CYC      = CLK25_POR_CYC,
  parameter int unsigned          HOLD_CYC     = CLK25_HOLD_CYC,
  parameter int unsigned          RST_BTN      = 0,
  parameter int unsigned          HB_CYC       = CLK25_HB_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             sys_rst_n,
  output logic             long_press,
  output logic             heartbeat
);

  if (N_BTN < 1 || DEBOUNCE_CYC < 1 || POR_CYC < 1 || HOLD_CYC < 1 || HB_CYC < 1
      || RST_BTN >= N_BTN) begin : g_bad_param
    $error("board_reset_input_cond: illegal parameter set");
  end

  localparam int unsigned PW = cnt_width(POR_CYC);
  localparam int unsigned HW = cnt_width(HOLD_CYC);
  localparam int unsigned BW = cnt_width(HB_CYC);
  localparam logic [PW-1:0] POR_MAX  = PW'(POR_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC - 1);
  localparam logic [BW-1:0] HB_MAX   = BW'(HB_CYC - 1);

  logic [N_BTN-1:0] w_btn_level;
  logic [N_BTN-1:0] w_btn_press;
  logic [N_BTN-1:0] w_btn_release;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .ACT_LOW     (BTN_ACT_LOW[g]),
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn_debounce (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw[g]),
      .btn_level  (w_btn_level[g]),
      .btn_press  (w_btn_press[g]),
      .btn_release(w_btn_release[g])
    );
  end

  brst_state_t   r_state;
  brst_state_t   w_next_state;
  logic          r_lock_s1;
  logic          r_lock_s2;
  logic [PW-1:0] r_cnt_por;
  logic [HW-1:0] r_hold_cnt;
  logic [BW-1:0] r_hb_cnt;
  logic          r_sys_rst_n;
  logic          r_long_press;
  logic          r_hb;
  logic          w_rst_btn;

  assign w_rst_btn = w_btn_level[RST_BTN];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= POR_WAIT;
    else        r_state <= w_next_state;
  end

  // Lock loss is checked first in every state so it outranks the long-press path
  always_comb begin
    w_next_state = r_state;
    if (!r_lock_s2) begin
      w_next_state = POR_WAIT;
    end else begin
      case (r_state)
        POR_WAIT: if (r_cnt_por == POR_MAX)   w_next_state = RUN;
        RUN:      if (r_hold_cnt == HOLD_MAX) w_next_state = HOLD_RST;
        HOLD_RST: if (!w_rst_btn)             w_next_state = POR_WAIT;
        default:                              w_next_state = POR_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_s1    <= 1'b0;
      r_lock_s2    <= 1'b0;
      r_cnt_por    <= '0;
      r_hold_cnt   <= '0;
      r_sys_rst_n  <= 1'b0;
      r_long_press <= 1'b0;
      r_hb_cnt     <= '0;
      r_hb         <= 1'b0;
    end else begin
      r_lock_s1 <= pll_locked;
      r_lock_s2 <= r_lock_s1;

      if (r_state == POR_WAIT && r_lock_s2 && r_cnt_por != POR_MAX) r_cnt_por <= r_cnt_por + PW'(1);
      else                                                          r_cnt_por <= '0;

      if (r_state == RUN && r_lock_s2 && w_rst_btn) begin
        if (r_hold_cnt != HOLD_MAX) r_hold_cnt <= r_hold_cnt + HW'(1);
      end else begin
        r_hold_cnt <= '0;
      end

      r_sys_rst_n  <= (r_state == RUN);
      r_long_press <= (r_state == HOLD_RST);

      if (!r_sys_rst_n) begin
        r_hb_cnt <= '0;
        r_hb     <= 1'b0;
      end else if (r_hb_cnt == HB_MAX) begin
        r_hb_cnt <= '0;
        r_hb     <= ~r_hb;
      end else begin
        r_hb_cnt <= r_hb_cnt + BW'(1);
      end
    end
  end

  assign btn_level   = w_btn_level;
  assign btn_press   = w_btn_press;
  assign btn_release = w_btn_release;
  assign sys_rst_n   = r_sys_rst_n;
  assign long_press  = r_long_press;
  assign heartbeat   = r_hb;

endmodule

// File: tb/tb_board_reset_input_cond.sv
// Directed bench for board_reset_input_cond: POR stretch, lock gating, debounce, polarity, long press, mid-run reset.
module tb_board_reset_input_cond;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic [2:0] btn_release;
  logic       sys_rst_n;
  logic       long_press;
  logic       heartbeat;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  board_reset_input_cond #(
    .N_BTN       (3),
    .BTN_ACT_LOW (3'b001),
    .DEBOUNCE_CYC(4),
    .POR_CYC     (8),
    .HOLD_CYC    (16),
    .RST_BTN     (0),
    .HB_CYC      (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .sys_rst_n  (sys_rst_n),
    .long_press (long_press),
    .heartbeat  (heartbeat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges; sample/drive 1 time unit after the last edge
  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, ".sys_rst_n"}, sys_rst_n, 0);
    check({tag, ".level"}, btn_level, 0);
    check({tag, ".press"}, btn_press, 0);
    check({tag, ".release"}, btn_release, 0);
    check({tag, ".long_press"}, long_press, 0);
    check({tag, ".heartbeat"}, heartbeat, 0);
  endtask

  int unsigned presses;
  int unsigned releases;
  int unsigned press_at;

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    btn_raw    = 3'b001;
    tick(3);
    check_all_reset("reset");

    // POR: lock seen after 2 edges, 8 counted cycles, then registered decode
    rst_n = 1'b1;
    tick(10);
    check("por_still_low", sys_rst_n, 0);
    tick(1);
    check("por_release", sys_rst_n, 1);
    check("hb_initial", heartbeat, 0);
    tick(4);
    check("hb_before_toggle", heartbeat, 0);
    tick(1);
    check("hb_first_toggle", heartbeat, 1);
    tick(5);
    check("hb_second_toggle", heartbeat, 0);

    // Debounce on channel 1 with a 1,0,1 bounce
    presses = 0; releases = 0; press_at = 0;
    btn_raw[1] = 1'b1; tick(1);
    btn_raw[1] = 1'b0; tick(1);
    btn_raw[1] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      if (btn_press[1]) begin presses++; press_at = i; end
      if (btn_release[1]) releases++;
    end
    check("deb_press_count", presses, 1);
    check("deb_press_cycle", press_at, 6);
    check("deb_no_release", releases, 0);
    check("deb_level", btn_level[1], 1);
    btn_raw[1] = 1'b0;
    tick(8);
    check("deb_level_released", btn_level[1], 0);

    // Polarity + long press on active-low channel 0
    presses = 0;
    btn_raw[0] = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      tick(1);
      if (btn_press[0]) presses++;
      if (c == 5)  check("pol_level_pre", btn_level[0], 0);
      if (c == 6)  check("pol_level", btn_level[0], 1);
      if (c == 22) check("lp_not_yet", long_press, 0);
      if (c == 22) check("lp_sys_still_up", sys_rst_n, 1);
      if (c == 23) check("lp_asserted", long_press, 1);
      if (c == 23) check("lp_sys_low", sys_rst_n, 0);
    end
    tick(7);
    check("pol_press_count", presses, 1);
    btn_raw[0] = 1'b1;
    tick(6);
    check("lp_release_pulse", btn_release[0], 1);
    check("lp_level_low", btn_level[0], 0);
    tick(1);
    check("lp_latched", long_press, 1);
    tick(1);
    check("lp_cleared", long_press, 0);
    check("lp_por_low", sys_rst_n, 0);
    tick(7);
    check("lp_por_still_low", sys_rst_n, 0);
    tick(1);
    check("lp_por_release", sys_rst_n, 1);

    // Lock gating: no lock at release, lock raised 20 cycles later
    rst_n = 1'b0; pll_locked = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("lock_wait", sys_rst_n, 0);
    pll_locked = 1'b1;
    tick(10);
    check("lock_por_low", sys_rst_n, 0);
    tick(1);
    check("lock_por_release", sys_rst_n, 1);
    pll_locked = 1'b0;
    tick(3);
    check("lockloss_still_up", sys_rst_n, 1);
    tick(1);
    check("lockloss_low", sys_rst_n, 0);
    tick(1);
    check("lockloss_hb", heartbeat, 0);
    pll_locked = 1'b1;
    tick(10);
    check("relock_low", sys_rst_n, 0);
    tick(1);
    check("relock_up", sys_rst_n, 1);

    // rst_n asserted while in HOLD_RST
    btn_raw[0] = 1'b0;
    tick(23);
    check("mid_lp", long_press, 1);
    rst_n = 1'b0;
    tick(1);
    check_all_reset("mid_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
